// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-backed UART transmitter: FSM states,
// register addresses, CTRL/STATUS bit positions and the CTRL reset value.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam logic [2:0] UART_ADDR_TXDATA = 3'd0;
  localparam logic [2:0] UART_ADDR_STATUS = 3'd1;
  localparam logic [2:0] UART_ADDR_DIV_LO = 3'd2;
  localparam logic [2:0] UART_ADDR_DIV_HI = 3'd3;
  localparam logic [2:0] UART_ADDR_CTRL   = 3'd4;
  localparam logic [2:0] UART_ADDR_LEVEL  = 3'd5;

  localparam int CTRL_PAR_EN   = 0;
  localparam int CTRL_PAR_ODD  = 1;
  localparam int CTRL_TWO_STOP = 2;
  localparam int CTRL_TX_EN    = 3;
  localparam int CTRL_IE_EMPTY = 4;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_FULL  = 2;
  localparam int STAT_OVF   = 3;

  localparam logic [7:0] CTRL_RESET = 8'h08;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head; push when full and pop
// when empty are ignored, push+pop in one cycle keeps the level unchanged.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define the contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign level = wr_ptr - rd_ptr;
  assign empty = (level == '0);
  assign full  = (level == (AW+1)'(DEPTH));

endmodule

// File: rtl/uart_tx_fifo.sv
// Register-mapped UART transmitter with TX FIFO, programmable divisor and frame
// format; parity support is built only when UART_TX_PARITY_EN is defined.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int                   DATA_BITS  = 8,
  parameter int                   FIFO_DEPTH = 16,
  parameter int                   DIV_WIDTH  = 16,
  parameter logic [DIV_WIDTH-1:0] PERIOD     = DIV_WIDTH'(8'h1A)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wren,
  input  logic       rden,
  input  logic [2:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       txout,
  output logic       irq
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

`ifdef UART_TX_PARITY_EN
  localparam logic [4:0] CTRL_WMASK = 5'h1F;
`else
  localparam logic [4:0] CTRL_WMASK = 5'h1C;
`endif

  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [DATA_BITS-1:0] fifo_head;
  logic [LW-1:0]        fifo_level;

  logic [DIV_WIDTH-1:0] div;
  logic [DIV_WIDTH-1:0] div_eff;
  logic [4:0]           ctrl;
  logic                 ovf;
  logic [7:0]           status;

  uart_state_t          state;
  logic [DIV_WIDTH-1:0] div_lat;
  logic [DIV_WIDTH-1:0] bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [2:0]           bit_idx;
  logic                 stop_idx;
  logic                 two_stop_lat;
  logic                 bit_end;
  logic                 wr_txdata;
  logic                 frame_done;
`ifdef UART_TX_PARITY_EN
  logic                 par_en_lat;
  logic                 parity_lat;
`endif

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (din[DATA_BITS-1:0]),
    .dout  (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  assign wr_txdata  = wren && (addr == UART_ADDR_TXDATA);
  assign fifo_push  = wr_txdata && !fifo_full;
  assign div_eff    = (div == '0) ? DIV_WIDTH'(1) : div;
  assign bit_end    = (bit_cnt == div_lat);
  assign frame_done = (state == ST_STOP) && bit_end && (stop_idx == two_stop_lat);
  assign fifo_pop   = !fifo_empty && ctrl[CTRL_TX_EN] && ((state == ST_IDLE) || frame_done);

  always_comb begin
    status             = '0;
    status[STAT_BUSY]  = (state != ST_IDLE);
    status[STAT_EMPTY] = fifo_empty;
    status[STAT_FULL]  = fifo_full;
    status[STAT_OVF]   = ovf;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div  <= PERIOD;
      ctrl <= CTRL_RESET[4:0];
      ovf  <= 1'b0;
      dout <= '0;
      irq  <= 1'b0;
    end else begin
      if (wren) begin
        case (addr)
          UART_ADDR_DIV_LO: div[7:0] <= din;
          UART_ADDR_DIV_HI: div[DIV_WIDTH-1:8] <= din[DIV_WIDTH-9:0];
          UART_ADDR_CTRL:   ctrl <= din[4:0] & CTRL_WMASK;
          default: ;
        endcase
      end
      // A dropped push wins over a same-cycle clear.
      if (wr_txdata && fifo_full)
        ovf <= 1'b1;
      else if (wren && (addr == UART_ADDR_STATUS))
        ovf <= 1'b0;
      if (rden) begin
        case (addr)
          UART_ADDR_STATUS: dout <= status;
          UART_ADDR_DIV_LO: dout <= div[7:0];
          UART_ADDR_DIV_HI: dout <= 8'(div >> 8);
          UART_ADDR_CTRL:   dout <= {3'b000, ctrl};
          UART_ADDR_LEVEL:  dout <= 8'(fifo_level);
          default:          dout <= '0;
        endcase
      end
      irq <= fifo_empty && ctrl[CTRL_TX_EN] && ctrl[CTRL_IE_EMPTY];
    end
  end

  // txout is driven from the current state, so the line lags the FSM by one
  // cycle; every bit still lasts exactly div_lat+1 cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      txout        <= 1'b1;
      div_lat      <= DIV_WIDTH'(1);
      bit_cnt      <= '0;
      shreg        <= '0;
      bit_idx      <= '0;
      stop_idx     <= 1'b0;
      two_stop_lat <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_lat   <= 1'b0;
      parity_lat   <= 1'b0;
`endif
    end else begin
      bit_cnt <= bit_end ? '0 : bit_cnt + 1'b1;
      case (state)
        ST_IDLE: begin
          txout   <= 1'b1;
          bit_cnt <= '0;
        end
        ST_START: begin
          txout <= 1'b0;
          if (bit_end) begin
            state   <= ST_DATA;
            bit_idx <= '0;
          end
        end
        ST_DATA: begin
          txout <= shreg[0];
          if (bit_end) begin
            shreg <= shreg >> 1;
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
              state    <= par_en_lat ? ST_PARITY : ST_STOP;
`else
              state    <= ST_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          txout <= parity_lat;
          if (bit_end) begin
            state    <= ST_STOP;
            stop_idx <= 1'b0;
          end
        end
`endif
        ST_STOP: begin
          txout <= 1'b1;
          if (bit_end) begin
            if (stop_idx == two_stop_lat) state <= ST_IDLE;
            else                          stop_idx <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          txout <= 1'b1;
        end
      endcase
      // Frame start overrides the per-state updates above.
      if (fifo_pop) begin
        state        <= ST_START;
        bit_cnt      <= '0;
        shreg        <= fifo_head;
        div_lat      <= div_eff;
        two_stop_lat <= ctrl[CTRL_TWO_STOP];
`ifdef UART_TX_PARITY_EN
        par_en_lat   <= ctrl[CTRL_PAR_EN];
        parity_lat   <= (^fifo_head) ^ ctrl[CTRL_PAR_ODD];
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: expected frames and register reads are
// queued by the stimulus and checked by independent line and bus monitors.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wren = 1'b0;
  logic       rden = 1'b0;
  logic [2:0] addr = '0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       txout;
  logic       irq;

  uart_tx_fifo dut (
    .clk   (clk),
    .reset (reset),
    .wren  (wren),
    .rden  (rden),
    .addr  (addr),
    .din   (din),
    .dout  (dout),
    .txout (txout),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         par;
    bit         parbit;
    bit         two;
    int         div;
  } frame_t;

  typedef struct {
    string      name;
    logic [7:0] val;
  } rd_t;

  frame_t exp_q[$];
  rd_t    rd_q[$];
  int     start_q[$];
  int     n_cmp = 0;
  int     n_fail = 0;
  int     cyc = 0;
  int     aborted = 0;
  bit     rst_seen = 0;
  bit     mon_active = 0;
  int     wr_cyc;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wren = 1'b1; addr = a; din = d;
    wr_cyc = cyc + 1;
    @(negedge clk);
    wren = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] e, input string name);
    rd_q.push_back('{name, e});
    rden = 1'b1; addr = a;
    @(negedge clk);
    rden = 1'b0;
  endtask

  task automatic exp_frame(input logic [7:0] d, input bit par, input bit pb, input bit two, input int dv);
    exp_q.push_back('{d, par, pb, two, dv});
  endtask

  task automatic wait_quiet(input int budget, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || mon_active || txout !== 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check({name, "_timeout"}, 32'(n), 32'(budget - 1));
    repeat (2) @(negedge clk);
  endtask

  // Serial line monitor: samples every cycle of every bit of a frame.
  task automatic run_frame();
    frame_t      e;
    logic [15:0] expb;
    logic [15:0] got;
    int          nbits;
    int          p;
    int          unstable;
    logic        first;
    start_q.push_back(cyc);
    if (exp_q.size() == 0) begin
      check("unexpected_frame", 32'(exp_q.size()), 32'd1);
      return;
    end
    mon_active = 1;
    e = exp_q.pop_front();
    expb = '0;
    for (int i = 0; i < 8; i++) expb[1+i] = e.data[i];
    nbits = 10 + int'(e.par) + int'(e.two);
    if (e.par) expb[9] = e.parbit;
    for (int i = 9 + int'(e.par); i < nbits; i++) expb[i] = 1'b1;
    p = e.div + 1;
    got = '0;
    unstable = 0;
    first = 1'b0;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < p; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        if (rst_seen) begin
          rst_seen = 0;
          aborted++;
          mon_active = 0;
          return;
        end
        if (c == 0) first = txout;
        else if (txout !== first) unstable++;
      end
      got[b] = first;
    end
    check("frame_bits", 32'(got), 32'(expb));
    check("bit_width", 32'(unstable), 32'd0);
    mon_active = 0;
  endtask

  initial begin
    logic prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_seen && !mon_active) rst_seen = 0;
      if (!reset && prev === 1'b1 && txout === 1'b0) run_frame();
      prev = txout;
    end
  end

  initial begin
    bit pend;
    rd_t r;
    forever begin
      @(posedge clk);
      pend = rden && !reset;
      @(negedge clk);
      if (pend) begin
        if (rd_q.size() == 0) check("unexpected_read", 32'(dout), 32'hFFFF);
        else begin
          r = rd_q.pop_front();
          check(r.name, 32'(dout), 32'(r.val));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected %0d reads and %0d frames pending", rd_q.size(), exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_txout", 32'(txout), 32'd1);
    check("reset_irq", 32'(irq), 32'd0);
    check("reset_dout", 32'(dout), 32'd0);
    rd(UART_ADDR_STATUS, 8'h02, "reset_status");
    rd(UART_ADDR_CTRL,   8'h08, "reset_ctrl");
    rd(UART_ADDR_DIV_LO, 8'h1A, "reset_div_lo");
    rd(UART_ADDR_DIV_HI, 8'h00, "reset_div_hi");
    rd(UART_ADDR_LEVEL,  8'h00, "reset_level");
    rd(3'd6,             8'h00, "addr6_read");

    // DIV=3, 0xA5, 8N1: 40-cycle frame, line falls 2 edges after the write.
    wr(UART_ADDR_DIV_LO, 8'h03);
    start_q.delete();
    exp_frame(8'hA5, 0, 0, 0, 3);
    wr(UART_ADDR_TXDATA, 8'hA5);
    wait_quiet(200, "a5");
    check("start_latency", 32'(start_q.size() > 0 ? start_q[0] - wr_cyc : -1), 32'd2);
    rd(UART_ADDR_STATUS, 8'h02, "idle_after_frame");
    rd(UART_ADDR_TXDATA, 8'h00, "txdata_read");

`ifdef UART_TX_PARITY_EN
    wr(UART_ADDR_CTRL, 8'h0B);
    rd(UART_ADDR_CTRL, 8'h0B, "ctrl_parity_rb");
    exp_frame(8'h03, 1, 1, 0, 3);
    wr(UART_ADDR_TXDATA, 8'h03);
    wait_quiet(200, "odd_par");
    wr(UART_ADDR_CTRL, 8'h09);
    exp_frame(8'h03, 1, 0, 0, 3);
    wr(UART_ADDR_TXDATA, 8'h03);
    wait_quiet(200, "even_par");
`else
    wr(UART_ADDR_CTRL, 8'h0B);
    rd(UART_ADDR_CTRL, 8'h08, "ctrl_parity_masked");
    exp_frame(8'h03, 0, 0, 0, 3);
    wr(UART_ADDR_TXDATA, 8'h03);
    wait_quiet(200, "no_par");
`endif

    // Two stop bits, back-to-back: starts are 11 bit periods apart.
    wr(UART_ADDR_CTRL, 8'h0C);
    start_q.delete();
    exp_frame(8'h00, 0, 0, 1, 3);
    exp_frame(8'hFF, 0, 0, 1, 3);
    wr(UART_ADDR_TXDATA, 8'h00);
    wr(UART_ADDR_TXDATA, 8'hFF);
    wait_quiet(400, "two_stop");
    check("b2b_spacing", 32'(start_q.size() == 2 ? start_q[1] - start_q[0] : -1), 32'd44);

    // Overflow with the transmitter disabled.
    wr(UART_ADDR_CTRL, 8'h00);
    for (int i = 0; i < 17; i++) wr(UART_ADDR_TXDATA, 8'(8'h10 + i));
    rd(UART_ADDR_LEVEL,  8'h10, "level_full");
    rd(UART_ADDR_STATUS, 8'h0C, "status_full_ovf");
    wr(UART_ADDR_STATUS, 8'h00);
    rd(UART_ADDR_STATUS, 8'h04, "status_ovf_cleared");

    // Enable, then reset in the middle of the first frame's data bits.
    start_q.delete();
    exp_frame(8'h10, 0, 0, 0, 3);
    wr(UART_ADDR_CTRL, 8'h08);
    begin
      int n = 0;
      while (start_q.size() == 0 && n < 20) begin @(negedge clk); n++; end
      check("mid_frame_start_seen", 32'(start_q.size()), 32'd1);
    end
    repeat (10) @(negedge clk);
    reset = 1'b1;
    rst_seen = 1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_mid_txout", 32'(txout), 32'd1);
    rd(UART_ADDR_LEVEL,  8'h00, "reset_mid_level");
    rd(UART_ADDR_DIV_LO, 8'h1A, "reset_mid_div_lo");
    rd(UART_ADDR_DIV_HI, 8'h00, "reset_mid_div_hi");
    rd(UART_ADDR_STATUS, 8'h02, "reset_mid_status");
    repeat (4) @(negedge clk);
    check("frame_aborted", 32'(aborted), 32'd1);
    check("no_frames_pending", 32'(exp_q.size()), 32'd0);

    // irq: drops the cycle after the push, rises once the pop empties the FIFO.
    wr(UART_ADDR_DIV_LO, 8'h03);
    wr(UART_ADDR_CTRL, 8'h18);
    exp_frame(8'h5A, 0, 0, 0, 3);
    wr(UART_ADDR_TXDATA, 8'h5A);
    check("irq_at_push", 32'(irq), 32'd1);
    @(negedge clk);
    check("irq_drop", 32'(irq), 32'd0);
    @(negedge clk);
    check("irq_rise", 32'(irq), 32'd1);
    wait_quiet(200, "irq_frame");

    // DIV=0 is treated as 1: two-cycle bits.
    wr(UART_ADDR_CTRL, 8'h08);
    wr(UART_ADDR_DIV_LO, 8'h00);
    exp_frame(8'h81, 0, 0, 0, 1);
    wr(UART_ADDR_TXDATA, 8'h81);
    wait_quiet(100, "div0");
    rd(UART_ADDR_DIV_LO, 8'h00, "div0_readback");
    repeat (3) @(negedge clk);
    check("reads_drained", 32'(rd_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
